// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, same-cycle imem lookup, small {pc,instr} FIFO to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misalign
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo [FIFO_DEPTH];
  entry_t        head;
  logic [31:0]   pc;
  logic [31:0]   target;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          halted, pop, push;

  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign pop       = if_valid & if_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push      = ~redirect_valid & ((count < DEPTH) | pop) & ~halted;
  assign head      = fifo[rd_ptr];
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted         <= 1'b0;
      fetch_misalign <= 1'b0;
    end else if (redirect_valid) begin
      halted         <= (redirect_pc[1:0] != 2'b00);
      fetch_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_lsb;
  assign unused_lsb     = ^redirect_pc[1:0];
  assign target         = {redirect_pc[31:2], 2'b00};
  assign halted         = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // A pop this cycle still reaches decode; everything left is discarded.
      pc     <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: pc, instr: imem_instr};
  end
endmodule
